// File: rtl/fft_pingpong_buf_if.sv
// Stream bundle between the ADC sample path, the ping-pong buffer and the FFT core.
// slave  : buffer side (takes in_valid/in_data/out_ready; drives in_ready/out_valid/out_data/out_last).
// master : producer/consumer side (the mirror image).
interface fft_pingpong_buf_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fft_pingpong_buf.sv
// Ping-pong frame buffer: one bank fills from the sample stream while the other drains, natural or bit-reversed order.
// Latency: bank FULL the cycle after its last write, first word valid one cycle later (1-clk RAM read).
// Backpressure: in_ready drops while the write bank is FULL/DRAINING; a stalled output holds address, data and last.
// Ports: clk, rst (async, active-high); bus (in/out valid-ready streams); bitrev_en (drain order, sampled at drain
// start); bank_full (per bank: FULL or DRAINING); frame_cnt (frames fully drained, wraps).
module fft_pingpong_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_pingpong_buf_if.slave    bus,
   input  logic                 bitrev_en,
   output logic [1:0]           bank_full,
   output logic [CNT_WIDTH-1:0] frame_cnt
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      B_EMPTY,
      B_FILLING,
      B_FULL,
      B_DRAINING
   } bank_st_t;

   // RD_ISSUE: reads still to issue; RD_TAIL: last read issued, waiting for its acceptance.
   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_TAIL
   } rd_st_t;

   bank_st_t               bank_q [2];
   bank_st_t               bank_d [2];
   rd_st_t                 rd_q;
   rd_st_t                 rd_d;
   logic                   wr_bank_q;
   logic                   rd_bank_q;
   logic [ADDR_WIDTH-1:0]  wr_cnt_q;
   logic [ADDR_WIDTH-1:0]  rd_cnt_q;
   logic                   rev_q;
   logic                   out_valid_q;
   logic                   out_last_q;
   logic [DATA_WIDTH-1:0]  rd_data_q;
   logic [CNT_WIDTH-1:0]   frame_cnt_q;
   logic [DATA_WIDTH-1:0]  mem [2*DEPTH];

   logic                   in_ready;
   logic                   wr_fire;
   logic                   wr_done;
   logic                   out_free;
   logic                   last_acc;
   logic                   rd_start;
   logic                   rd_issue;
   logic [ADDR_WIDTH-1:0]  rd_addr;

   function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] r;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         r[i] = a[ADDR_WIDTH-1-i];
      end
      return r;
   endfunction

   assign in_ready = !rst && ((bank_q[wr_bank_q] == B_EMPTY) || (bank_q[wr_bank_q] == B_FILLING));
   assign wr_fire  = bus.in_valid && in_ready;
   assign wr_done  = wr_fire && (wr_cnt_q == LAST_ADDR);

   // The output register is the RAM read register, so a new read may only overwrite it
   // once the word currently presented has been taken (or nothing is presented).
   assign out_free = !out_valid_q || bus.out_ready;
   assign last_acc = out_valid_q && out_last_q && bus.out_ready;
   assign rd_addr  = rev_q ? bit_reverse(rd_cnt_q) : rd_cnt_q;

   // Reader FSM: next state and read strobes.
   always_comb begin
      rd_d     = rd_q;
      rd_start = 1'b0;
      rd_issue = 1'b0;
      case (rd_q)
         RD_IDLE: begin
            // Only an idle reader starts a drain; this leaves one empty output cycle between frames.
            if (bank_q[rd_bank_q] == B_FULL) begin
               rd_start = 1'b1;
               rd_issue = 1'b1;
               rd_d     = RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            if (out_free) begin
               rd_issue = 1'b1;
               if (rd_cnt_q == LAST_ADDR) begin
                  rd_d = RD_TAIL;
               end
            end
         end
         RD_TAIL: begin
            if (last_acc) begin
               rd_d = RD_IDLE;
            end
         end
         default: rd_d = RD_IDLE;
      endcase
   end

   // Bank state next values. Write-side events only touch an EMPTY/FILLING bank and
   // read-side events only a FULL/DRAINING one, so both sides apply in the same cycle.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_d[b] = bank_q[b];
         if (wr_fire && (wr_bank_q == 1'(b))) begin
            bank_d[b] = wr_done ? B_FULL : B_FILLING;
         end
         if (rd_start && (rd_bank_q == 1'(b))) begin
            bank_d[b] = B_DRAINING;
         end
         if (last_acc && (rd_bank_q == 1'(b))) begin
            bank_d[b] = B_EMPTY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q[0]   <= B_EMPTY;
         bank_q[1]   <= B_EMPTY;
         rd_q        <= RD_IDLE;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         rev_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         bank_q[0] <= bank_d[0];
         bank_q[1] <= bank_d[1];
         rd_q      <= rd_d;

         if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + ADDR_WIDTH'(1);
         end
         if (wr_done) begin
            wr_bank_q <= ~wr_bank_q;
         end

         if (rd_start) begin
            rev_q <= bitrev_en;
         end
         if (rd_issue) begin
            rd_cnt_q    <= rd_cnt_q + ADDR_WIDTH'(1);
            out_valid_q <= 1'b1;
            out_last_q  <= (rd_cnt_q == LAST_ADDR);
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (last_acc) begin
            rd_bank_q   <= ~rd_bank_q;
            frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // Simple dual-port storage addressed as {bank, addr}; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[{wr_bank_q, wr_cnt_q}] <= bus.in_data;
      end
      if (rd_issue) begin
         rd_data_q <= mem[{rd_bank_q, rd_addr}];
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = rd_data_q;
   assign bus.out_last  = out_valid_q && out_last_q;

   assign bank_full[0] = (bank_q[0] == B_FULL) || (bank_q[0] == B_DRAINING);
   assign bank_full[1] = (bank_q[1] == B_FULL) || (bank_q[1] == B_DRAINING);
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// Self-checking bench for fft_pingpong_buf with DEPTH=8: vector table of frames plus hand-written
// sequences for backpressure, random stalls, reset mid-fill/mid-drain and back-to-back streaming.
// Expected output words are queued when a frame is driven and compared as the DUT emits them.
module tb_fft_pingpong_buf;
   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam int CW    = 16;
   localparam int DEPTH = 8;
   localparam int REV8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   typedef struct {
      logic [DW-1:0] d;
      logic          last;
   } exp_t;

   typedef struct {
      logic          rev;
      logic [DW-1:0] base;
      logic [DW-1:0] exp [DEPTH];
      logic [CW-1:0] cnt;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bitrev_en = 1'b0;
   logic [1:0]    bank_full;
   logic [CW-1:0] frame_cnt;

   fft_pingpong_buf_if #(.DATA_WIDTH(DW)) bus ();

   fft_pingpong_buf #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .bitrev_en(bitrev_en),
      .bank_full(bank_full),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   frames_done = 0;
   int   words_out = 0;
   int   gaps_seen = 0;
   int   gap_cnt = 0;
   bit   gap_chk_en = 1'b0;
   bit   after_last = 1'b0;
   bit   stall_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Output monitor: samples mid-cycle what the next rising edge will act on.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         exp_q.delete();
         frames_done = 0;
         words_out   = 0;
         stall_prev  = 1'b0;
         after_last  = 1'b0;
         gap_cnt     = 0;
      end else begin
         exp_t e;
         if (stall_prev) begin
            check("stall_valid", 64'(bus.out_valid), 64'(1));
            check("stall_data", 64'(bus.out_data), 64'(prev_data));
            check("stall_last", 64'(bus.out_last), 64'(prev_last));
         end
         if (after_last) begin
            if (bus.out_valid) begin
               if (gap_chk_en) begin
                  check("frame_gap", 64'(gap_cnt), 64'(1));
                  gaps_seen++;
               end
               after_last = 1'b0;
            end else begin
               gap_cnt++;
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 64'(bus.out_data), 64'(e.d));
               check("out_last", 64'(bus.out_last), 64'(e.last));
            end
            words_out++;
            if (bus.out_last) begin
               frames_done++;
               after_last = 1'b1;
               gap_cnt    = 0;
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end
   end

   task automatic push_frame(input logic [DW-1:0] base, input bit rev);
      for (int k = 0; k < DEPTH; k++) begin
         exp_t e;
         e.d    = base + DW'(rev ? REV8[k] : k);
         e.last = (k == DEPTH-1);
         exp_q.push_back(e);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the word was taken.
   task automatic send_word(input logic [DW-1:0] d);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      #1;
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout actual=0 required=1 word=%0h", d);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_run(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         send_word(base + DW'(i));
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
         @(negedge clk);
         #3;
         n++;
      end
      check("drain_done", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_bank_full", 64'(bank_full), 64'(0));
      check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vec_t tbl [4];
      int   n;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      tbl[0] = '{rev: 1'b0, base: 32'h0,
                 exp: '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7}, cnt: 16'd1};
      tbl[1] = '{rev: 1'b1, base: 32'h0,
                 exp: '{32'h0, 32'h4, 32'h2, 32'h6, 32'h1, 32'h5, 32'h3, 32'h7}, cnt: 16'd2};
      tbl[2] = '{rev: 1'b1, base: 32'h100,
                 exp: '{32'h100, 32'h104, 32'h102, 32'h106, 32'h101, 32'h105, 32'h103, 32'h107}, cnt: 16'd3};
      tbl[3] = '{rev: 1'b0, base: 32'hA0,
                 exp: '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7}, cnt: 16'd4};

      // Reset values, then single frames in natural and bit-reversed order.
      do_reset();
      #1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
      check("post_rst_out_last", 64'(bus.out_last), 64'(0));
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         bitrev_en     = tbl[v].rev;
         bus.out_ready = 1'b1;
         for (int k = 0; k < DEPTH; k++) begin
            exp_t e;
            e.d    = tbl[v].exp[k];
            e.last = (k == DEPTH-1);
            exp_q.push_back(e);
         end
         for (int k = 0; k < DEPTH; k++) begin
            send_word(tbl[v].base + DW'(k));
         end
         #1;
         check("lat_before", 64'(bus.out_valid), 64'(0));
         check("bank_full_one", 64'(bank_full), 64'((v % 2 == 1) ? 2'b10 : 2'b01));
         @(negedge clk);
         #1;
         check("lat_first", 64'(bus.out_valid), 64'(1));
         wait_drain();
         check("tbl_frame_cnt", 64'(frame_cnt), 64'(tbl[v].cnt));
         check("tbl_bank_full", 64'(bank_full), 64'(0));
      end

      // Both banks full under output backpressure, then release.
      do_reset();
      bus.out_ready = 1'b0;
      bitrev_en     = 1'b0;
      push_frame(32'd0, 1'b0);
      push_frame(32'd8, 1'b0);
      push_frame(32'd16, 1'b0);
      send_run(32'd0, 16);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd16;
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_bank_full", 64'(bank_full), 64'(2'b11));
      repeat (3) @(negedge clk);
      #1;
      check("bp_in_ready_held", 64'(bus.in_ready), 64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_out_data", 64'(bus.out_data), 64'(0));
      @(negedge clk);
      bus.out_ready = 1'b1;
      send_run(32'd16, 8);
      wait_drain();
      check("bp_frame_cnt", 64'(frame_cnt), 64'(3));
      check("bp_bank_full_end", 64'(bank_full), 64'(0));

      // Random output stalls during a bit-reversed drain.
      do_reset();
      bitrev_en = 1'b1;
      push_frame(32'h40, 1'b1);
      fork
         send_run(32'h40, 8);
         begin
            for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
               @(negedge clk);
               bus.out_ready = 1'($urandom_range(0, 1));
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_drain();
      check("rnd_frame_cnt", 64'(frame_cnt), 64'(1));

      // Reset mid-fill and mid-drain.
      bitrev_en     = 1'b0;
      bus.out_ready = 1'b1;
      do_reset();
      send_run(32'h30, 5);
      do_reset();
      push_frame(32'h50, 1'b0);
      send_run(32'h50, 8);
      n = 0;
      while (words_out < 3 && n < 100) begin
         @(negedge clk);
         #3;
         n++;
      end
      check("mid_drain_reached", 64'(words_out >= 3), 64'(1));
      do_reset();
      push_frame(32'h60, 1'b0);
      send_run(32'h60, 8);
      wait_drain();
      check("rst_recover_cnt", 64'(frame_cnt), 64'(1));
      check("rst_recover_bank", 64'(bank_full), 64'(0));

      // Three frames back to back; bitrev_en flips during the second drain.
      do_reset();
      bus.out_ready = 1'b1;
      bitrev_en     = 1'b0;
      push_frame(32'h70, 1'b0);
      push_frame(32'h78, 1'b0);
      push_frame(32'h80, 1'b1);
      gaps_seen  = 0;
      gap_chk_en = 1'b1;
      fork
         send_run(32'h70, 24);
         begin
            int m = 0;
            while (frames_done < 1 && m < 200) begin
               @(negedge clk);
               #3;
               m++;
            end
            do begin
               @(negedge clk);
               #3;
               m++;
            end while (!bus.out_valid && m < 200);
            bitrev_en = 1'b1;
         end
      join
      wait_drain();
      gap_chk_en = 1'b0;
      check("b2b_gaps_seen", 64'(gaps_seen), 64'(2));
      check("b2b_frame_cnt", 64'(frame_cnt), 64'(3));
      check("b2b_bank_full", 64'(bank_full), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
